capture_ctrl: RTL

//  Sequences sample capture into the five channel RAMs of the logic analyzer.

---
 rtl/capture_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: controls how samples are captured into the five channel RAMs
// of the logic analyzer. It drives the shared write enable and write address,
// sets armed once the pre-trigger window holds enough samples, latches the
// trigger, counts the post-trigger samples, and pulses set_capture_done when
// the capture is complete.
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            capture_done,
  input  logic            wrt_smpl,
  input  logic            trig_in,
  input  logic [LOG2-1:0] trig_pos,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic [LOG2-1:0] ram_addr,
  output logic            armed,
  output logic            triggered,
  output logic            set_capture_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Highest RAM index, and the full window depth. smpl_cnt needs one extra
  // bit because it saturates at ENTRIES rather than ENTRIES-1.
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   FULL = (LOG2 + 1)'(ENTRIES);

  state_t          state;
  state_t          state_nxt;
  logic            start;
  logic            complete;
  logic [LOG2-1:0] tp_eff;
  logic [LOG2:0]   arm_thresh;
  logic [LOG2:0]   smpl_cnt;
  logic [LOG2-1:0] trig_cnt;

  // trig_pos comes from a wider host register. Values past the last RAM
  // entry are clamped so that at least one pre-trigger sample is kept.
  assign tp_eff     = (trig_pos > LAST) ? LAST : trig_pos;
  assign arm_thresh = FULL - {1'b0, tp_eff};
  assign complete   = triggered && (trig_cnt == tp_eff);

  // Next-state and write-enable decode. we is combinational so that a write
  // happens in the same cycle as the wrt_smpl strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first. Any path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    we        = 1'b0;
    start     = 1'b0;
    unique case (state)
      IDLE: begin
        if (run && !capture_done) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (complete) begin
          state_nxt = DONE;
        end else begin
          we = wrt_smpl;
        end
      end
      DONE: begin
        // cmd_cfg registers capture_done from our pulse one clock later. That
        // means the input is still low during the pulse cycle, so it must not
        // count as the host clearing it.
        if (!capture_done && !set_capture_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= only. Each register then
    // samples its old value at the edge, whatever order the statements are in.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write address and last-written entry. They advance together on each
  // write and wrap at ENTRIES. Both keep their values between captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr    <= '0;
      ram_addr <= LAST;
    end else if (we) begin
      waddr    <= (waddr == LAST) ? '0 : waddr + 1'b1;
      ram_addr <= waddr;
    end
  end

  // Pre-trigger and post-trigger sample counters. They are cleared when a
  // capture starts. A write in the same cycle that trig_in rises still counts
  // as pre-trigger, because triggered is a registered flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      smpl_cnt <= '0;
      trig_cnt <= '0;
    end else if (start) begin
      smpl_cnt <= '0;
      trig_cnt <= '0;
    end else if (we) begin
      if (!triggered) begin
        if (smpl_cnt != FULL) smpl_cnt <= smpl_cnt + 1'b1;
      end else begin
        trig_cnt <= trig_cnt + 1'b1;
      end
    end
  end

  // armed and triggered are sticky for the whole capture. A trigger is only
  // accepted after armed has been registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      triggered <= 1'b0;
    end else if (start) begin
      armed     <= 1'b0;
      triggered <= 1'b0;
    end else if (state == RUN) begin
      if (smpl_cnt >= arm_thresh) armed     <= 1'b1;
      if (armed && trig_in)       triggered <= 1'b1;
    end
  end

  // One-cycle done pulse. It is issued on the transition into DONE and is
  // high during the first DONE cycle only.
  always_ff @(posedge clk) begin
    if (rst) set_capture_done <= 1'b0;
    else     set_capture_done <= (state == RUN) && run && complete;
  end

endmodule
